bp_fe_bp_update_queue: RTL and testbench
========================================

Name: bp_fe_bp_update_queue

Overview:
- Driver-side companion to the two-level local branch predictor.
- Issues predictor read requests on fetch and records each prediction with its BHT index in an in-order queue.
- On in-order branch resolution, pops the head and drives the predictor's write port: valid, index, correct flag.
- Sits in the FE between the fetch PC logic and the predictor; also keeps saturating accuracy counters.

Parameters:
- bht_idx_width_p, 9, width of the predictor BHT index.
- queue_els_p, 8, number of in-flight prediction entries; must be a power of 2 and at least 2.
- ctr_width_p, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- fetch_v_i  in  1  new branch fetched; accepted only when fetch_ready_o=1
- fetch_idx_i  in  bht_idx_width_p  BHT index of the fetched branch
- fetch_ready_o  out  1  queue not full
- pred_taken_o  out  1  prediction for the current fetch, combinational; equals predict_i when fetch_v_i&fetch_ready_o, else 0
- r_v_o  out  1  predictor read valid; equals fetch_v_i & fetch_ready_o
- idx_r_o  out  bht_idx_width_p  predictor read index; equals fetch_idx_i
- predict_i  in  1  predictor output, same cycle as r_v_o
- resolve_v_i  in  1  oldest in-flight branch resolved
- resolve_taken_i  in  1  actual outcome
- flush_i  in  1  discard all unresolved entries
- w_v_o  out  1  predictor update valid (registered)
- idx_w_o  out  bht_idx_width_p  predictor update index (registered)
- correct_o  out  1  1 when the recorded prediction equals the actual outcome (registered)
- count_o  out  $clog2(queue_els_p)+1  current occupancy
- n_updates_o  out  ctr_width_p  total updates issued, saturating
- n_mispred_o  out  ctr_width_p  updates with correct_o=0, saturating
- underflow_o  out  1  sticky flag: resolve_v_i seen while empty

Behaviour:
- Reset: queue empty, count_o=0, all read and write pointers 0; w_v_o=0, idx_w_o=0, correct_o=0; both counters 0; underflow_o=0; fetch_ready_o=1. Reset overrides every other input in the same cycle.
- Entry format: {idx, pred}.
- Push: when fetch_v_i & fetch_ready_o & ~flush_i, write {fetch_idx_i, predict_i} at the tail and increment the write pointer modulo queue_els_p. A fetch in a flush cycle gets no push, but r_v_o still follows the rule above.
- fetch_ready_o = (count_o != queue_els_p). There is no same-cycle pop-and-push bypass when full.
- Pop: when resolve_v_i and count_o>0, read the head and increment the read pointer modulo queue_els_p.
- Update output, on the next cycle after a pop: w_v_o=1, idx_w_o=head.idx, correct_o=(head.pred==resolve_taken_i). Otherwise w_v_o=0 and idx_w_o/correct_o hold their last values. Update latency is exactly 1 cycle after resolve.
- Resolve while empty: no pop, w_v_o=0 next cycle, underflow_o set until reset.
- Simultaneous push and pop: both happen and count_o is unchanged. This is legal when 0<count_o<queue_els_p. When count_o=0 the resolve is an underflow and the push still happens.
- Flush: resolve in the same cycle is processed first and its update is issued. Then the queue empties at the cycle edge (pointers equal, count_o=0). Counters are not cleared.
- Pointers are log2(queue_els_p) bits with natural wrap. Occupancy is tracked with a separate count register of width $clog2(queue_els_p)+1.
- Counters increment on each cycle where w_v_o is asserted: n_updates_o always, n_mispred_o when correct_o=0. Both saturate at all-ones.

Decomposition:
- Package bp_fe_bp_pkg holds:
  - typedef bp_pred_entry_s {logic [bht_idx_width_p-1:0] idx; logic pred;}, built with a parameterised struct macro;
  - localparam ptr_width = $clog2(queue_els_p).
- One sub-module, bp_fe_bp_pred_fifo: circular buffer with push, pop, flush, count and full/empty outputs.
- Top level contains the predictor handshake, the registered update stage and the counters.

Test Plan:
- Reset then 3 fetches (idx 5/7/9, predict_i 1/0/1), then resolves taken 1/1/0 one per cycle -> w_v_o pulses 1 cycle after each resolve; idx_w_o=5,7,9; correct_o=1,0,0; n_updates_o=3, n_mispred_o=2.
- Fill with 8 fetches -> fetch_ready_o=0 and count_o=8; 9th fetch gives r_v_o=0 and no push. One resolve -> fetch_ready_o=1 the next cycle.
- Wrap: repeated push/pop for 20 entries at occupancy 3 -> idx_w_o order matches fetch order, no loss.
- Simultaneous fetch (idx 3) and resolve with count_o=1 -> count_o stays 1; the next resolve updates idx 3.
- Flush with 4 queued plus a same-cycle resolve -> one update for the head, then count_o=0. A following resolve sets underflow_o and gives w_v_o=0.
- Force n_mispred_o near all-ones (ctr_width_p=4), issue 20 mispredicts -> counter holds 15.

Source files
------------

// File: rtl/bp_fe_bp_pkg.sv
// Shared types for the branch-predictor update queue: the queued prediction
// entry and the default pointer width.
`ifndef BP_PRED_ENTRY_S
`define BP_PRED_ENTRY_S(name, idx_w) \
  typedef struct packed { \
    logic [(idx_w)-1:0] idx; \
    logic               pred; \
  } name;
`endif

package bp_fe_bp_pkg;

  localparam int bht_idx_width_lp = 9;
  localparam int queue_els_lp     = 8;
  localparam int ptr_width        = $clog2(queue_els_lp);

  `BP_PRED_ENTRY_S(bp_pred_entry_s, bht_idx_width_lp)

endpackage

// File: rtl/bp_fe_bp_pred_fifo.sv
// Circular buffer of in-flight predictions. Flush empties the buffer after
// any same-cycle pop has read the head.
module bp_fe_bp_pred_fifo #(
  parameter int width_p = 10,
  parameter int els_p   = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [width_p-1:0]       data_o,
  output logic [$clog2(els_p):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int ptr_w = $clog2(els_p);

  logic [width_p-1:0] r_mem [els_p];
  logic [ptr_w-1:0]   r_wptr;
  logic [ptr_w-1:0]   r_rptr;
  logic [ptr_w:0]     r_count;

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + 1'b1;
      if (pop_i)  r_rptr <= r_rptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rptr];
  assign count_o = r_count;
  assign full_o  = (r_count == (ptr_w+1)'(els_p));
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/bp_fe_bp_update_queue.sv
// Front-end companion to the local branch predictor: issues reads on fetch,
// queues {idx, pred}, and writes back correctness on in-order resolution.
module bp_fe_bp_update_queue
  import bp_fe_bp_pkg::*;
#(
  parameter int bht_idx_width_p = 9,
  parameter int queue_els_p     = 8,
  parameter int ctr_width_p     = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         fetch_v_i,
  input  logic [bht_idx_width_p-1:0]   fetch_idx_i,
  output logic                         fetch_ready_o,
  output logic                         pred_taken_o,
  output logic                         r_v_o,
  output logic [bht_idx_width_p-1:0]   idx_r_o,
  input  logic                         predict_i,
  input  logic                         resolve_v_i,
  input  logic                         resolve_taken_i,
  input  logic                         flush_i,
  output logic                         w_v_o,
  output logic [bht_idx_width_p-1:0]   idx_w_o,
  output logic                         correct_o,
  output logic [$clog2(queue_els_p):0] count_o,
  output logic [ctr_width_p-1:0]       n_updates_o,
  output logic [ctr_width_p-1:0]       n_mispred_o,
  output logic                         underflow_o
);

  `BP_PRED_ENTRY_S(entry_t, bht_idx_width_p)

  entry_t w_fetch_entry;
  entry_t w_head;
  logic   w_accept;
  logic   w_push;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;

  // Fetch handshake: a fetch transfers when fetch_v_i & fetch_ready_o; the
  // predictor read fires on that transfer even in a flush cycle, but only
  // non-flush transfers are queued.
  assign w_accept      = fetch_v_i & fetch_ready_o;
  assign w_push        = w_accept & ~flush_i;
  assign w_pop         = resolve_v_i & ~w_empty;
  assign fetch_ready_o = ~w_full;
  assign r_v_o         = w_accept;
  assign idx_r_o       = fetch_idx_i;
  assign pred_taken_o  = w_accept & predict_i;

  assign w_fetch_entry = '{idx: fetch_idx_i, pred: predict_i};

  bp_fe_bp_pred_fifo #(
    .width_p ($bits(entry_t)),
    .els_p   (queue_els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .data_i  (w_fetch_entry),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .data_o  (w_head),
    .count_o (count_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Update stage: idx/correct hold their last values between pops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_v_o       <= 1'b0;
      idx_w_o     <= '0;
      correct_o   <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      w_v_o <= w_pop;
      if (w_pop) begin
        idx_w_o   <= w_head.idx;
        correct_o <= (w_head.pred == resolve_taken_i);
      end
      if (resolve_v_i && w_empty) underflow_o <= 1'b1;
    end
  end

  // Statistics track the update already on the write port.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      n_updates_o <= '0;
      n_mispred_o <= '0;
    end else if (w_v_o) begin
      if (n_updates_o != '1) n_updates_o <= n_updates_o + 1'b1;
      if (!correct_o && (n_mispred_o != '1)) n_mispred_o <= n_mispred_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Bench for bp_fe_bp_update_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_bp_fe_bp_update_queue;

  localparam int IW  = 9;
  localparam int QE  = 8;
  localparam int CW  = 32;
  localparam int CWS = 4;
  localparam longint CAP  = 64'h0000_0000_FFFF_FFFF;
  localparam longint CAPS = 15;

  // clock / reset
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic          fetch_v_i, predict_i, resolve_v_i, resolve_taken_i, flush_i;
  logic [IW-1:0] fetch_idx_i;
  logic          fetch_ready_o, pred_taken_o, r_v_o, w_v_o, correct_o, underflow_o;
  logic [IW-1:0] idx_r_o, idx_w_o;
  logic [3:0]    count_o;
  logic [CW-1:0] n_updates_o, n_mispred_o;

  logic          s_fetch_ready_o, s_pred_taken_o, s_r_v_o, s_w_v_o, s_correct_o, s_underflow_o;
  logic [IW-1:0] s_idx_r_o, s_idx_w_o;
  logic [3:0]    s_count_o;
  logic [CWS-1:0] s_n_updates_o, s_n_mispred_o;

  bp_fe_bp_update_queue #(.bht_idx_width_p(IW), .queue_els_p(QE), .ctr_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .fetch_v_i(fetch_v_i), .fetch_idx_i(fetch_idx_i),
    .fetch_ready_o(fetch_ready_o), .pred_taken_o(pred_taken_o), .r_v_o(r_v_o),
    .idx_r_o(idx_r_o), .predict_i(predict_i), .resolve_v_i(resolve_v_i),
    .resolve_taken_i(resolve_taken_i), .flush_i(flush_i), .w_v_o(w_v_o),
    .idx_w_o(idx_w_o), .correct_o(correct_o), .count_o(count_o),
    .n_updates_o(n_updates_o), .n_mispred_o(n_mispred_o), .underflow_o(underflow_o));

  bp_fe_bp_update_queue #(.bht_idx_width_p(IW), .queue_els_p(QE), .ctr_width_p(CWS)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .fetch_v_i(fetch_v_i), .fetch_idx_i(fetch_idx_i),
    .fetch_ready_o(s_fetch_ready_o), .pred_taken_o(s_pred_taken_o), .r_v_o(s_r_v_o),
    .idx_r_o(s_idx_r_o), .predict_i(predict_i), .resolve_v_i(resolve_v_i),
    .resolve_taken_i(resolve_taken_i), .flush_i(flush_i), .w_v_o(s_w_v_o),
    .idx_w_o(s_idx_w_o), .correct_o(s_correct_o), .count_o(s_count_o),
    .n_updates_o(s_n_updates_o), .n_mispred_o(s_n_mispred_o), .underflow_o(s_underflow_o));

  // scoreboard / reference model
  int n_tests = 0;
  int n_fail  = 0;
  logic [IW:0]   exp_q[$];
  logic          exp_wv, exp_corr, exp_uf;
  logic [IW-1:0] exp_idx;
  longint        exp_nu, exp_nm, exp_snu, exp_snm;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat_inc(input longint v, input longint cap);
    return (v < cap) ? v + 1 : v;
  endfunction

  task automatic check_regs();
    check("count", longint'(count_o), longint'(exp_q.size()));
    check("w_v", longint'(w_v_o), longint'(exp_wv));
    check("idx_w", longint'(idx_w_o), longint'(exp_idx));
    check("correct", longint'(correct_o), longint'(exp_corr));
    check("underflow", longint'(underflow_o), longint'(exp_uf));
    check("n_updates", longint'(n_updates_o), exp_nu);
    check("n_mispred", longint'(n_mispred_o), exp_nm);
    check("sat_n_updates", longint'(s_n_updates_o), exp_snu);
    check("sat_n_mispred", longint'(s_n_mispred_o), exp_snm);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    fetch_v_i = 1'b1; fetch_idx_i = IW'($urandom_range(0, 511)); predict_i = 1'b1;
    resolve_v_i = 1'b1; resolve_taken_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    fetch_v_i = 1'b0; resolve_v_i = 1'b0;
    exp_q.delete();
    exp_wv = 1'b0; exp_idx = '0; exp_corr = 1'b0; exp_uf = 1'b0;
    exp_nu = 0; exp_nm = 0; exp_snu = 0; exp_snm = 0;
    check_regs();
    check("rst_ready", longint'(fetch_ready_o), 1);
  endtask

  // driver: one clock cycle with the given inputs
  task automatic cycle(input logic fv, input logic [IW-1:0] fidx, input logic pr,
                       input logic rv, input logic rt, input logic fl);
    logic  ready, accept;
    logic [IW:0] e;
    fetch_v_i = fv; fetch_idx_i = fidx; predict_i = pr;
    resolve_v_i = rv; resolve_taken_i = rt; flush_i = fl;
    #1;
    ready  = (exp_q.size() != QE);
    accept = fv && ready;
    check("fetch_ready", longint'(fetch_ready_o), longint'(ready));
    check("r_v", longint'(r_v_o), longint'(accept));
    check("pred_taken", longint'(pred_taken_o), longint'(accept && pr));
    check("idx_r", longint'(idx_r_o), longint'(fidx));
    if (exp_wv) begin
      exp_nu  = sat_inc(exp_nu, CAP);
      exp_snu = sat_inc(exp_snu, CAPS);
      if (!exp_corr) begin
        exp_nm  = sat_inc(exp_nm, CAP);
        exp_snm = sat_inc(exp_snm, CAPS);
      end
    end
    if (rv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_wv = 1'b1; exp_idx = e[IW:1]; exp_corr = (e[0] == rt);
    end else begin
      exp_wv = 1'b0;
      if (rv) exp_uf = 1'b1;
    end
    if (accept && !fl) exp_q.push_back({fidx, pr});
    if (fl) exp_q.delete();
    @(posedge clk); #1;
    fetch_v_i = 1'b0; resolve_v_i = 1'b0; flush_i = 1'b0;
    check_regs();
  endtask

  initial begin
    reset_i = 1'b1;
    fetch_v_i = 1'b0; fetch_idx_i = '0; predict_i = 1'b0;
    resolve_v_i = 1'b0; resolve_taken_i = 1'b0; flush_i = 1'b0;
    do_reset();

    // three fetches then three resolves
    cycle(1, 9'd5, 1, 0, 0, 0);
    cycle(1, 9'd7, 0, 0, 0, 0);
    cycle(1, 9'd9, 1, 0, 0, 0);
    cycle(0, 9'd0, 0, 1, 1, 0);
    check("dir_idx0", longint'(idx_w_o), 5);
    cycle(0, 9'd0, 0, 1, 1, 0);
    check("dir_idx1", longint'(idx_w_o), 7);
    cycle(0, 9'd0, 0, 1, 0, 0);
    check("dir_idx2", longint'(idx_w_o), 9);
    check("dir_corr2", longint'(correct_o), 0);
    cycle(0, 9'd0, 0, 0, 0, 0);
    check("dir_nupd", longint'(n_updates_o), 3);
    check("dir_nmis", longint'(n_mispred_o), 2);

    // fill, blocked ninth fetch, then drain one
    for (int i = 0; i < QE; i++) cycle(1, IW'(20 + i), i[0], 0, 0, 0);
    check("full_ready", longint'(fetch_ready_o), 0);
    cycle(1, 9'd99, 1, 0, 0, 0);
    check("full_count", longint'(count_o), 8);
    cycle(0, 9'd0, 0, 1, 1, 0);
    check("after_pop_ready", longint'(fetch_ready_o), 1);

    // wrap at occupancy 3
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, IW'(100 + i), 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, IW'(103 + i), i[1], 1, i[0], 0);

    // simultaneous push/pop at count 1
    do_reset();
    cycle(1, 9'd1, 0, 0, 0, 0);
    cycle(1, 9'd3, 1, 1, 0, 0);
    check("simul_count", longint'(count_o), 1);
    cycle(0, 9'd0, 0, 1, 1, 0);
    check("simul_idx", longint'(idx_w_o), 3);

    // flush with resolve, then underflow
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, IW'(40 + i), 0, 0, 0, 0);
    cycle(1, 9'd50, 1, 1, 0, 1);
    check("flush_idx", longint'(idx_w_o), 40);
    cycle(0, 9'd0, 0, 1, 1, 0);
    check("uf_flag", longint'(underflow_o), 1);
    check("uf_wv", longint'(w_v_o), 0);

    // saturation of narrow counters
    do_reset();
    cycle(1, 9'd7, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, IW'(i), 1, 1, 0, 0);
    cycle(0, 9'd0, 0, 0, 0, 0);
    check("sat_hold", longint'(s_n_mispred_o), 15);

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(($urandom_range(0, 9) < 6), IW'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 5), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
